// File: rtl/input_conditioner_pkg.sv
// Shared constants for the input conditioner and game logic: debounce FSM state
// encodings, button bit indices and the counter sizing helper.
package input_conditioner_pkg;

    localparam int NUM_BTN = 5;
    localparam int NUM_SW  = 4;

    localparam int BTN_C = 0;
    localparam int BTN_L = 1;
    localparam int BTN_R = 2;
    localparam int BTN_U = 3;
    localparam int BTN_D = 4;

    typedef logic [1:0] db_state_t;

    localparam db_state_t ST_STABLE_LO = 2'd0;
    localparam db_state_t ST_WAIT_HI   = 2'd1;
    localparam db_state_t ST_STABLE_HI = 2'd2;
    localparam db_state_t ST_WAIT_LO   = 2'd3;

    // Counter must hold (largest interval - 1); never narrower than one bit.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return (m > 2) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/input_conditioner_if.sv
// Raw board inputs and conditioned outputs of the input conditioner.
interface input_conditioner_if;
    import input_conditioner_pkg::*;

    logic               BtnC;
    logic               BtnL;
    logic               BtnR;
    logic               BtnU;
    logic               BtnD;
    logic [NUM_SW-1:0]  Sw;
    logic [NUM_BTN-1:0] Btn_level;
    logic [NUM_BTN-1:0] Btn_press;
    logic [NUM_BTN-1:0] Btn_release;
    logic [NUM_SW-1:0]  Sw_level;
    logic [NUM_SW-1:0]  Sw_change;

    modport master (
        output BtnC, BtnL, BtnR, BtnU, BtnD, Sw,
        input  Btn_level, Btn_press, Btn_release, Sw_level, Sw_change
    );

    modport slave (
        input  BtnC, BtnL, BtnR, BtnU, BtnD, Sw,
        output Btn_level, Btn_press, Btn_release, Sw_level, Sw_change
    );

endinterface

// File: rtl/input_conditioner_debounce_channel.sv
// One debounced input: 2-flop synchronizer, 4-state debounce FSM and shared counter.
// Auto-repeat of the rising pulse on held buttons is built only with BTN_REPEAT_EN.
module debounce_channel
    import input_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_PERIOD   = 10000000,
    parameter bit IS_BUTTON       = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_raw,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
    localparam bit DB_ONE = (DEBOUNCE_CYCLES <= 1);
    localparam logic [CNT_W:0] DB_LAST    = (CNT_W+1)'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W:0] REP_DELAY  = (CNT_W+1)'(REPEAT_DELAY);
    localparam logic [CNT_W:0] REP_PERIOD = (CNT_W+1)'(REPEAT_PERIOD);

`ifdef BTN_REPEAT_EN
    localparam bit REPEAT_ON = IS_BUTTON;
`else
    localparam bit REPEAT_ON = 1'b0 && IS_BUTTON;
`endif

    logic             r_sync1;
    logic             r_sync2;
    db_state_t        r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_level;
    logic             r_rise;
    logic             r_fall;
    logic             r_rep_armed;
    logic [CNT_W:0]   w_cnt_inc;
    logic             w_sample;

    assign w_sample  = r_sync2;
    assign w_cnt_inc = {1'b0, r_cnt} + 1'b1;

    // The entering sample counts as the first stable one, so acceptance fires on the
    // DEBOUNCE_CYCLES-th consecutive sample: 2 + DEBOUNCE_CYCLES cycles after a raw edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1     <= 1'b0;
            r_sync2     <= 1'b0;
            r_state     <= ST_STABLE_LO;
            r_cnt       <= '0;
            r_level     <= 1'b0;
            r_rise      <= 1'b0;
            r_fall      <= 1'b0;
            r_rep_armed <= 1'b0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
            case (r_state)
                ST_STABLE_LO: begin
                    if (w_sample) begin
                        r_cnt <= '0;
                        if (DB_ONE) begin
                            r_state     <= ST_STABLE_HI;
                            r_level     <= 1'b1;
                            r_rise      <= 1'b1;
                            r_rep_armed <= 1'b0;
                        end else begin
                            r_state <= ST_WAIT_HI;
                        end
                    end
                end
                ST_WAIT_HI: begin
                    if (!w_sample) begin
                        r_state <= ST_STABLE_LO;
                        r_cnt   <= '0;
                    end else if (w_cnt_inc == DB_LAST) begin
                        r_state     <= ST_STABLE_HI;
                        r_cnt       <= '0;
                        r_level     <= 1'b1;
                        r_rise      <= 1'b1;
                        r_rep_armed <= 1'b0;
                    end else begin
                        r_cnt <= w_cnt_inc[CNT_W-1:0];
                    end
                end
                ST_STABLE_HI: begin
                    if (!w_sample) begin
                        r_cnt <= '0;
                        if (DB_ONE) begin
                            r_state <= ST_STABLE_LO;
                            r_level <= 1'b0;
                            r_fall  <= 1'b1;
                        end else begin
                            r_state <= ST_WAIT_LO;
                        end
                    end else if (REPEAT_ON) begin
                        // First repeat waits REPEAT_DELAY, later ones REPEAT_PERIOD.
                        if (w_cnt_inc == (r_rep_armed ? REP_PERIOD : REP_DELAY)) begin
                            r_cnt       <= '0;
                            r_rise      <= 1'b1;
                            r_rep_armed <= 1'b1;
                        end else begin
                            r_cnt <= w_cnt_inc[CNT_W-1:0];
                        end
                    end
                end
                ST_WAIT_LO: begin
                    if (w_sample) begin
                        r_state     <= ST_STABLE_HI;
                        r_cnt       <= '0;
                        r_rep_armed <= 1'b1;
                    end else if (w_cnt_inc == DB_LAST) begin
                        r_state <= ST_STABLE_LO;
                        r_cnt   <= '0;
                        r_level <= 1'b0;
                        r_fall  <= 1'b1;
                    end else begin
                        r_cnt <= w_cnt_inc[CNT_W-1:0];
                    end
                end
                default: begin
                    r_state <= ST_STABLE_LO;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign o_level = r_level;
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;

endmodule

// File: rtl/input_conditioner.sv
// Debounces five pushbuttons and four slide switches into levels and edge pulses.
// Define BTN_REPEAT_EN to add auto-repeat press pulses on held buttons.
module input_conditioner
    import input_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_PERIOD   = 10000000
) (
    input  logic                Clk,
    input  logic                Reset,
    input_conditioner_if.slave  bus
);

    logic [NUM_BTN-1:0] w_btn_raw;
    logic [NUM_BTN-1:0] w_btn_level;
    logic [NUM_BTN-1:0] w_btn_rise;
    logic [NUM_BTN-1:0] w_btn_fall;
    logic [NUM_SW-1:0]  w_sw_level;
    logic [NUM_SW-1:0]  w_sw_rise;
    logic [NUM_SW-1:0]  w_sw_fall;

    assign w_btn_raw[BTN_C] = bus.BtnC;
    assign w_btn_raw[BTN_L] = bus.BtnL;
    assign w_btn_raw[BTN_R] = bus.BtnR;
    assign w_btn_raw[BTN_U] = bus.BtnU;
    assign w_btn_raw[BTN_D] = bus.BtnD;

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
        debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD),
            .IS_BUTTON       (1'b1)
        ) u_chan (
            .i_clk   (Clk),
            .i_rst_n (Reset),
            .i_raw   (w_btn_raw[g]),
            .o_level (w_btn_level[g]),
            .o_rise  (w_btn_rise[g]),
            .o_fall  (w_btn_fall[g])
        );
    end

    for (genvar g = 0; g < NUM_SW; g++) begin : g_sw
        debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD),
            .IS_BUTTON       (1'b0)
        ) u_chan (
            .i_clk   (Clk),
            .i_rst_n (Reset),
            .i_raw   (bus.Sw[g]),
            .o_level (w_sw_level[g]),
            .o_rise  (w_sw_rise[g]),
            .o_fall  (w_sw_fall[g])
        );
    end

    assign bus.Btn_level   = w_btn_level;
    assign bus.Btn_press   = w_btn_rise;
    assign bus.Btn_release = w_btn_fall;
    assign bus.Sw_level    = w_sw_level;
    assign bus.Sw_change   = w_sw_rise | w_sw_fall;

endmodule

// File: doc/input_conditioner.md
INPUT_CONDITIONER -- requirements
Module: input_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000000 (10 ms at 100 MHz), is the number of consecutive stable synchronized samples required to accept a new level.
REQ-002 Parameter REPEAT_DELAY, default 50000000, is the cycles from press pulse to first auto-repeat pulse (used only with BTN_REPEAT_EN).
REQ-003 Parameter REPEAT_PERIOD, default 10000000, is the cycles between subsequent auto-repeat pulses (used only with BTN_REPEAT_EN).
REQ-004 Clk  input  1  system clock; all state on rising edge.
REQ-005 Reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-006 BtnC, BtnL, BtnR, BtnU, BtnD  input  1 each  raw asynchronous pushbuttons, active-high.
REQ-007 Sw  input  4  raw asynchronous slide switches Sw[3:0], active-high.
REQ-008 Btn_level  output  5  debounced button levels; bit order [0]=C, [1]=L, [2]=R, [3]=U, [4]=D.
REQ-009 Btn_press  output  5  one-cycle pulse per debounced rising edge (plus repeats when enabled); same bit order.
REQ-010 Btn_release  output  5  one-cycle pulse per debounced falling edge; same bit order.
REQ-011 Sw_level  output  4  debounced switch levels.
REQ-012 Sw_change  output  4  one-cycle pulse on any debounced switch transition.

Function
REQ-013 Each of the 9 channels SHALL pass its raw input through a 2-flop synchronizer before any other logic.
REQ-014 Each channel SHALL run a 4-state FSM: STABLE_LO, WAIT_HI, STABLE_HI, WAIT_LO.
REQ-015 STABLE_LO -> WAIT_HI when the synchronized sample is 1; the counter clears.
REQ-016 WAIT_HI SHALL increment the counter while the sample is 1 and return to STABLE_LO (counter cleared, no pulse) on any 0 sample.
REQ-017 WAIT_HI -> STABLE_HI when the counter reaches DEBOUNCE_CYCLES-1 with the sample still 1; level goes 1 and the rising pulse asserts in the same cycle.
REQ-018 STABLE_HI/WAIT_LO SHALL mirror REQ-015..017 with polarity inverted; on acceptance, level goes 0 and the falling pulse asserts.
REQ-019 Latency from a clean raw edge to level change and pulse SHALL be exactly 2 + DEBOUNCE_CYCLES cycles.
REQ-020 Pulses SHALL be exactly one cycle wide; at most one edge pulse per channel per cycle.
REQ-021 Counter width SHALL be clog2 of the largest of DEBOUNCE_CYCLES, REPEAT_DELAY and REPEAT_PERIOD, and SHALL never wrap.
REQ-022 Channels SHALL be fully independent; simultaneous edges on several channels SHALL produce simultaneous pulses.
REQ-023 Sw_change[i] SHALL pulse on both rising and falling debounced edges of Sw[i].

Reset
REQ-024 While Reset=0, all synchronizer flops, counters, and outputs SHALL be 0 and every FSM SHALL be in STABLE_LO.
REQ-025 An input held high through reset release SHALL debounce normally, producing a level rise and a press/change pulse 2 + DEBOUNCE_CYCLES cycles after release.
REQ-026 Reset asserted mid-WAIT SHALL abort the pending transition without emitting a pulse.

Configuration
REQ-027 With BTN_REPEAT_EN defined, a button held in STABLE_HI SHALL emit an extra Btn_press pulse REPEAT_DELAY cycles after the initial press, then every REPEAT_PERIOD cycles until it leaves STABLE_HI.
REQ-028 The repeat timer SHALL clear on entry to WAIT_LO, and a bounce that returns to STABLE_HI SHALL restart timing at REPEAT_PERIOD.
REQ-029 Without BTN_REPEAT_EN, Btn_press SHALL fire only on debounced rising edges, and the repeat logic and parameters SHALL be unused.
REQ-030 Switch channels SHALL never auto-repeat.

Structure
REQ-031 The FSM state encodings and the button bit-index constants (C/L/R/U/D) SHALL live in the shared project package/header, also used by first-person game logic.
REQ-032 One sub-module, debounce_channel (synchronizer + FSM + counter, with an IS_BUTTON parameter), SHALL be instantiated 9 times.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=8, REPEAT_PERIOD=3)
REQ-033 BtnC clean rise at cycle 0 -> Btn_level[0]=1 and one-cycle Btn_press[0] at cycle 6; clean fall -> Btn_release[0] 6 cycles later.
REQ-034 BtnL toggles 1,0,1,0 every cycle, then holds 1 -> no pulse during bouncing; a single Btn_press[1] 6 cycles after the final stable rise.
REQ-035 Sw[2] raised, then lowered after 20 cycles -> Sw_level[2] rises then falls, with two Sw_change[2] pulses.
REQ-036 BtnU and Sw[0] rise in the same cycle -> Btn_press[3] and Sw_change[0] pulse in the same cycle.
REQ-037 Reset driven to 0 two cycles into WAIT_HI, then released with the input low -> no pulse, all outputs 0.
REQ-038 BTN_REPEAT_EN defined, BtnD held for 30 cycles -> Btn_press[4] pulses at the initial press, +8, +11, +14, ..., and stops after debounced release.
